// File: rtl/reset_sequencer.sv
// Staged reset release: a hold interval, then one channel per stagger interval.
// Restarts on a debounced button press or a software request.
module reset_sequencer #(
    parameter int unsigned COUNT_WIDTH     = 23,
    parameter int unsigned STAGGER_WIDTH   = 16,
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                BTNS,
    input  logic                SoftReq,
    output logic [CHANNELS-1:0] Reset,
    output logic                Ready,
    output logic [1:0]          Cause
);

    localparam int unsigned DEB_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IDX_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DEB_WIDTH-1:0] DEB_MAX = DEB_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [DEB_WIDTH-1:0] DEB_ARM = DEB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_CHAN = IDX_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t                   state;
    logic                     btn_meta;
    logic                     btn_sync;
    logic [DEB_WIDTH-1:0]     deb_cnt;
    logic                     btn_req;
    logic                     any_req;
    logic [COUNT_WIDTH-1:0]   hold_cnt;
    logic [STAGGER_WIDTH-1:0] stag_cnt;
    logic [IDX_WIDTH-1:0]     chan;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= BTNS;
            btn_sync <= btn_meta;
            if (!btn_sync) begin
                deb_cnt <= '0;
            end else if (deb_cnt < DEB_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Looks one count ahead so the restart lands on the edge the count reaches the threshold.
    assign btn_req = btn_sync && (deb_cnt >= DEB_ARM);
    assign any_req = btn_req || SoftReq;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= HOLD;
            Reset    <= '1;
            Ready    <= 1'b0;
            Cause    <= 2'd0;
            hold_cnt <= '0;
            stag_cnt <= '0;
            chan     <= '0;
        end else if (any_req) begin
            state    <= HOLD;
            Reset    <= '1;
            Ready    <= 1'b0;
            Cause    <= btn_req ? 2'd1 : 2'd2;
            hold_cnt <= '0;
            stag_cnt <= '0;
            chan     <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (hold_cnt == '1) begin
                        Reset[0] <= 1'b0;
                        stag_cnt <= '0;
                        if (CHANNELS == 1) begin
                            state <= RUN;
                            Ready <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            chan  <= IDX_WIDTH'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stag_cnt == '1) begin
                        Reset    <= Reset & ~(CHANNELS'(1) << chan);
                        stag_cnt <= '0;
                        if (chan == LAST_CHAN) begin
                            state <= RUN;
                            Ready <= 1'b1;
                        end else begin
                            chan <= chan + 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random button/soft traffic
// compared each cycle against an edge-count reference model.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int unsigned CW   = 4;
    localparam int unsigned SW   = 2;
    localparam int unsigned CH   = 3;
    localparam int unsigned DEB  = 3;
    localparam int          HOLD_EDGES = 1 << CW;
    localparam int          STAG_EDGES = 1 << SW;

    logic          Clk;
    logic          nReset;
    logic          BTNS;
    logic          SoftReq;
    logic [CH-1:0] Reset;
    logic          Ready;
    logic [1:0]    Cause;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges since the last restart, last cause, button sample history.
    int       t;
    logic [1:0] m_cause;
    bit       hist[$];

    reset_sequencer #(
        .COUNT_WIDTH    (CW),
        .STAGGER_WIDTH  (SW),
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .BTNS   (BTNS),
        .SoftReq(SoftReq),
        .Reset  (Reset),
        .Ready  (Ready),
        .Cause  (Cause)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_clear();
        t       = 0;
        m_cause = 2'd0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
    endfunction

    // A button press counts once it has been high for DEB samples, seen two edges late.
    function automatic void model_edge();
        bit btn;
        if (nReset !== 1'b1) return;
        hist.push_front(BTNS);
        void'(hist.pop_back());
        btn = 1'b1;
        for (int i = 2; i < DEB + 2; i++) if (!hist[i]) btn = 1'b0;
        if (btn || SoftReq) begin
            t       = 0;
            m_cause = btn ? 2'd1 : 2'd2;
        end else if (t < 1000) begin
            t = t + 1;
        end
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CH-1:0] exp_reset;
        for (int k = 0; k < int'(CH); k++) exp_reset[k] = (t < HOLD_EDGES + k * STAG_EDGES);
        check_val({tag, ".reset"}, 8'(Reset), 8'(exp_reset));
        check_val({tag, ".ready"}, 8'(Ready), 8'(t >= HOLD_EDGES + (int'(CH) - 1) * STAG_EDGES));
        check_val({tag, ".cause"}, 8'(Cause), 8'(m_cause));
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        nReset  = 1'b0;
        BTNS    = 1'b0;
        SoftReq = 1'b0;
        model_clear();

        // Held in reset
        run("in_reset", 3);
        check_val("reset_state", 8'(Reset), 8'h07);

        // Power-up timing
        #2 nReset = 1'b1;
        run("powerup", 15);
        check_val("pu_edge15", 8'(Reset), 8'h07);
        tick("powerup");
        check_val("pu_edge16", 8'(Reset), 8'h06);
        run("powerup", 3);
        check_val("pu_edge19", 8'(Reset), 8'h06);
        tick("powerup");
        check_val("pu_edge20", 8'(Reset), 8'h04);
        run("powerup", 4);
        check_val("pu_edge24", 8'(Reset), 8'h00);
        check_val("pu_ready24", 8'(Ready), 8'h01);
        run("powerup", 6);

        // Short glitch ignored
        BTNS = 1'b1;
        run("glitch_short", 2);
        BTNS = 1'b0;
        run("glitch_short", 8);
        check_val("glitch_ready", 8'(Ready), 8'h01);

        // Long press restarts on the fifth edge
        BTNS = 1'b1;
        run("press", 4);
        check_val("press_edge4", 8'(Ready), 8'h01);
        tick("press");
        check_val("press_edge5", 8'(Reset), 8'h07);
        check_val("press_cause", 8'(Cause), 8'h01);
        run("press", 5);
        BTNS = 1'b0;
        run("press_release", 40);

        // Soft request from RUN, then again mid-RELEASE
        SoftReq = 1'b1;
        tick("soft_run");
        SoftReq = 1'b0;
        run("soft_seq", 23);
        SoftReq = 1'b1;
        tick("soft_release");
        check_val("soft_rel_reset", 8'(Reset), 8'h07);
        check_val("soft_rel_cause", 8'(Cause), 8'h02);
        SoftReq = 1'b0;
        run("soft_restart", 30);

        // Soft request during HOLD
        SoftReq = 1'b1;
        tick("soft_hold_a");
        SoftReq = 1'b0;
        run("soft_hold", 7);
        SoftReq = 1'b1;
        tick("soft_hold_b");
        SoftReq = 1'b0;
        run("soft_hold", 30);

        // Button and soft together
        BTNS = 1'b1;
        run("simul", 4);
        SoftReq = 1'b1;
        tick("simul");
        check_val("simul_cause", 8'(Cause), 8'h01);
        SoftReq = 1'b0;
        BTNS    = 1'b0;
        run("simul_after", 35);

        // Asynchronous reset in RELEASE
        SoftReq = 1'b1;
        tick("async_pre");
        SoftReq = 1'b0;
        run("async_pre", 20);
        #2 nReset = 1'b0;
        model_clear();
        #1;
        check_model("async_now");
        check_val("async_reset", 8'(Reset), 8'h07);
        run("async_low", 3);
        nReset = 1'b1;
        run("async_restart", 30);

        // Random traffic
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            BTNS = ($urandom_range(0, 3) == 0);
            len  = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                SoftReq = ($urandom_range(0, 39) == 0);
                tick("random");
            end
            SoftReq = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                #2 nReset = 1'b0;
                model_clear();
                #1;
                check_model("random_async");
                tick("random_async");
                nReset = 1'b1;
            end
        end
        BTNS    = 1'b0;
        SoftReq = 1'b0;
        run("random_tail", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
